// File: rtl/ucie_ctl_sb_rx_packet_assembler.sv
// rtl/ucie_ctl_sb_rx_packet_assembler.sv - sideband RX chunk counter, word pairing and packet FIFO
// Gates the external 32-bit shift register, pairs two completed words per packet, queues packets.
module ucie_ctl_sb_rx_packet_assembler #(
  parameter int NC    = 8,
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_chunk_valid,
  input  logic        i_sync,
  output logic        o_shift_en,
  input  logic [31:0] i_shift_word,
  output logic        o_pkt_valid,
  output logic [63:0] o_pkt_data,
  input  logic        i_pkt_ready,
  output logic        o_fifo_full,
  output logic        o_overflow,
  input  logic        i_clr_ovf
);

  localparam int CHUNKS = 32 / NC;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW     = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
  localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);

  logic [CW-1:0] chunk_cnt;
  logic          half;
  logic          word_done;
  logic [31:0]   pkt_lo;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic          push;
  logic          pop;
  logic          accept;
  logic          drop;

  assign o_shift_en  = i_chunk_valid & i_enable;
  assign o_pkt_valid = (count != '0);
  assign o_fifo_full = (count == OW'(DEPTH));
  assign o_pkt_data  = o_pkt_valid ? mem[rd_ptr] : '0;

  // A resync in the capture cycle wins, so a half-built packet can never be pushed.
  assign push   = word_done & half & ~i_sync;
  assign pop    = o_pkt_valid & i_pkt_ready;
  assign accept = push & (~o_fifo_full | pop);
  assign drop   = push & o_fifo_full & ~pop;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      chunk_cnt  <= '0;
      half       <= 1'b0;
      word_done  <= 1'b0;
      pkt_lo     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_sync) begin
        chunk_cnt <= '0;
        half      <= 1'b0;
        word_done <= 1'b0;
      end else begin
        word_done <= o_shift_en && (chunk_cnt == LAST_CHUNK);
        if (o_shift_en)
          chunk_cnt <= (chunk_cnt == LAST_CHUNK) ? '0 : chunk_cnt + CW'(1);
        // The shift register holds the full word in the cycle after the wrap,
        // regardless of whether a new chunk shifts in at the end of that cycle.
        if (word_done) begin
          if (!half) begin
            pkt_lo <= i_shift_word;
            half   <= 1'b1;
          end else begin
            half   <= 1'b0;
          end
        end
      end

      if (accept)
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PW'(1);
      if (accept && !pop)
        count <= count + OW'(1);
      else if (pop && !accept)
        count <= count - OW'(1);

      if (drop)
        o_overflow <= 1'b1;
      else if (i_clr_ovf)
        o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept)
      mem[wr_ptr] <= {i_shift_word, pkt_lo};
  end

endmodule

// File: tb/tb_ucie_ctl_sb_rx_packet_assembler.sv
// tb/tb_ucie_ctl_sb_rx_packet_assembler.sv - directed bench for the sideband RX packet assembler
// Models the external 8-bit-chunk shift register feeding the assembler.
module tb_ucie_ctl_sb_rx_packet_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cv = 1'b0;
  logic        sync = 1'b0;
  logic        shift_en;
  logic [31:0] sr;
  logic [7:0]  chunk = 8'h00;
  logic        pkt_valid;
  logic [63:0] pkt_data;
  logic        ready = 1'b0;
  logic        fifo_full;
  logic        ovf;
  logic        clr_ovf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] seq1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sr <= 32'h0;
    else if (shift_en)
      sr <= {sr[23:0], chunk};
  end

  ucie_ctl_sb_rx_packet_assembler #(.NC(8), .DEPTH(2)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .i_chunk_valid (cv),
    .i_sync        (sync),
    .o_shift_en    (shift_en),
    .i_shift_word  (sr),
    .o_pkt_valid   (pkt_valid),
    .o_pkt_data    (pkt_data),
    .i_pkt_ready   (ready),
    .o_fifo_full   (fifo_full),
    .o_overflow    (ovf),
    .i_clr_ovf     (clr_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    chunk = c;
    cv = 1'b1;
    en = 1'b1;
    step();
    cv = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] base);
    for (int i = 0; i < 8; i++)
      send(base + 8'(i));
  endtask

  initial begin
    // Reset state; shift enable stays combinational during reset
    cv = 1'b1;
    en = 1'b1;
    #1;
    chk("rst_shift_en", {63'h0, shift_en}, 64'h1);
    cv = 1'b0;
    #1;
    chk("rst_shift_en_off", {63'h0, shift_en}, 64'h0);
    step();
    chk("rst_valid", {63'h0, pkt_valid}, 64'h0);
    chk("rst_data", pkt_data, 64'h0);
    chk("rst_full", {63'h0, fifo_full}, 64'h0);
    chk("rst_ovf", {63'h0, ovf}, 64'h0);
    rst_n = 1'b1;
    step();

    // Back-to-back stream, ready=1: valid exactly two edges after the last shift
    ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(seq1[i]);
    chk("t1_valid_T1", {63'h0, pkt_valid}, 64'h0);
    step();
    chk("t1_valid_T2", {63'h0, pkt_valid}, 64'h1);
    chk("t1_data", pkt_data, 64'h5566778811223344);
    step();
    chk("t1_popped", {63'h0, pkt_valid}, 64'h0);
    ready = 1'b0;

    // Gaps and enable-low pulses between chunks
    for (int i = 0; i < 8; i++) begin
      en = 1'b0;
      cv = 1'b1;
      chunk = 8'hFF;
      #1;
      chk("t2_shift_en_gated", {63'h0, shift_en}, 64'h0);
      step();
      cv = 1'b0;
      en = 1'b1;
      step();
      send(seq1[i]);
    end
    step();
    chk("t2_valid", {63'h0, pkt_valid}, 64'h1);
    chk("t2_data", pkt_data, 64'h5566778811223344);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t2_popped", {63'h0, pkt_valid}, 64'h0);

    // Resync in the capture cycle discards the first four chunks
    send_pkt(8'h01);
    for (int i = 0; i < 4; i++)
      send(8'h01 + 8'(i));
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("t3_pre_valid", {63'h0, pkt_valid}, 64'h1);
    chk("t3_pre_data", pkt_data, 64'h0506070801020304);
    ready = 1'b1;
    step();
    ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(8'hA8 - 8'(i));
    step();
    chk("t3_valid", {63'h0, pkt_valid}, 64'h1);
    chk("t3_data", pkt_data, 64'hA4A3A2A1A8A7A6A5);
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    step();
    chk("t3_single_pkt", {63'h0, pkt_valid}, 64'h0);

    // ready=0: two queue, third dropped, sticky overflow then clear
    send_pkt(8'h01);
    send_pkt(8'h11);
    step();
    chk("t4_full", {63'h0, fifo_full}, 64'h1);
    chk("t4_ovf_before", {63'h0, ovf}, 64'h0);
    send_pkt(8'h21);
    step();
    chk("t4_ovf_set", {63'h0, ovf}, 64'h1);
    chk("t4_head", pkt_data, 64'h0506070801020304);
    step();
    chk("t4_ovf_sticky", {63'h0, ovf}, 64'h1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", {63'h0, ovf}, 64'h0);
    ready = 1'b1;
    step();
    chk("t4_second", pkt_data, 64'h1516171811121314);
    chk("t4_not_full", {63'h0, fifo_full}, 64'h0);
    step();
    chk("t4_empty", {63'h0, pkt_valid}, 64'h0);
    ready = 1'b0;

    // Full FIFO with a pop in the push cycle: nothing dropped, order kept
    send_pkt(8'h01);
    send_pkt(8'h11);
    step();
    chk("t5_full", {63'h0, fifo_full}, 64'h1);
    send_pkt(8'h21);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t5_no_ovf", {63'h0, ovf}, 64'h0);
    chk("t5_still_full", {63'h0, fifo_full}, 64'h1);
    chk("t5_head_p2", pkt_data, 64'h1516171811121314);
    ready = 1'b1;
    step();
    chk("t5_head_p3", pkt_data, 64'h2526272821222324);
    step();
    chk("t5_empty", {63'h0, pkt_valid}, 64'h0);
    ready = 1'b0;

    // Async reset mid-packet with a packet queued
    send_pkt(8'h31);
    step();
    chk("t6_queued", {63'h0, pkt_valid}, 64'h1);
    for (int i = 0; i < 5; i++)
      send(8'h41 + 8'(i));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'h0, pkt_valid}, 64'h0);
    chk("t6_rst_data", pkt_data, 64'h0);
    chk("t6_rst_full", {63'h0, fifo_full}, 64'h0);
    chk("t6_rst_ovf", {63'h0, ovf}, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    send_pkt(8'h51);
    step();
    chk("t6_post_valid", {63'h0, pkt_valid}, 64'h1);
    chk("t6_post_data", pkt_data, 64'h5556575851525354);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
